lsu_arbiter: RTL and testbench

// - Shares one data-memory port among THREADS_PER_BLOCK per-thread LSUs within a core.
// - Sits between the core's LSUs and the core's memory channel toward the memory controller.
// - Issues one read or write at a time to memory, chosen by round-robin, and returns the

---
 rtl/lsu_arbiter_pkg.sv | 27 ++
 rtl/lsu_arbiter_if.sv | 41 ++++
 rtl/lsu_arbiter_rr_picker.sv | 42 ++++
 rtl/lsu_arbiter.sv | 155 +++++++++++++++
 tb/tb_lsu_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_arbiter_pkg.sv
// Shared types and constants for the LSU-to-memory arbiter slice.
package lsu_arbiter_pkg;

  localparam int LSU_COUNT     = 4;
  localparam int LSU_ADDR_BITS = 8;
  localparam int LSU_DATA_BITS = 8;

  // Memory-side request levels; a request is held until the matching ready.
  localparam logic MEM_REQ_ON  = 1'b1;
  localparam logic MEM_REQ_OFF = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_READ_WAIT  = 2'd1,
    ST_WRITE_WAIT = 2'd2,
    ST_RELAY      = 2'd3
  } arb_state_t;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/lsu_arbiter_if.sv
// LSU-side and memory-side bus of the arbiter; slave = arbiter, master = LSUs plus memory.
interface lsu_arbiter_if
  import lsu_arbiter_pkg::*;
#(
  parameter int N  = LSU_COUNT,
  parameter int AW = LSU_ADDR_BITS,
  parameter int DW = LSU_DATA_BITS
);
  logic [N-1:0]         lsu_read_valid;
  logic [N-1:0][AW-1:0] lsu_read_address;
  logic [N-1:0]         lsu_read_ready;
  logic [N-1:0][DW-1:0] lsu_read_data;
  logic [N-1:0]         lsu_write_valid;
  logic [N-1:0][AW-1:0] lsu_write_address;
  logic [N-1:0][DW-1:0] lsu_write_data;
  logic [N-1:0]         lsu_write_ready;
  logic                 mem_read_valid;
  logic [AW-1:0]        mem_read_address;
  logic                 mem_read_ready;
  logic [DW-1:0]        mem_read_data;
  logic                 mem_write_valid;
  logic [AW-1:0]        mem_write_address;
  logic [DW-1:0]        mem_write_data;
  logic                 mem_write_ready;
  logic                 busy;

  modport slave (
    input  lsu_read_valid, lsu_read_address, lsu_write_valid, lsu_write_address,
           lsu_write_data, mem_read_ready, mem_read_data, mem_write_ready,
    output lsu_read_ready, lsu_read_data, lsu_write_ready, mem_read_valid,
           mem_read_address, mem_write_valid, mem_write_address, mem_write_data, busy
  );

  modport master (
    output lsu_read_valid, lsu_read_address, lsu_write_valid, lsu_write_address,
           lsu_write_data, mem_read_ready, mem_read_data, mem_write_ready,
    input  lsu_read_ready, lsu_read_data, lsu_write_ready, mem_read_valid,
           mem_read_address, mem_write_valid, mem_write_address, mem_write_data, busy
  );

endinterface

// File: rtl/lsu_arbiter_rr_picker.sv
// Round-robin pick: rotate requests so i_ptr sits at bit 0, take the lowest set bit, rotate back.
module rr_picker
  import lsu_arbiter_pkg::*;
#(
  parameter int N  = LSU_COUNT,
  parameter int IW = idx_bits(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IW-1:0]  w_off;
  logic [IW:0]    w_sum;

  // Rotate, priority-encode from the pointer upward, then map back to an LSU index.
  always_comb begin
    w_dbl   = {i_req, i_req} >> i_ptr;
    w_rot   = w_dbl[N-1:0];
    o_found = 1'b0;
    w_off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_found = 1'b1;
        w_off   = IW'(k);
      end else begin
        o_found = o_found;
      end
    end
    w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    if (w_sum >= (IW+1)'(N)) begin
      w_sum = w_sum - (IW+1)'(N);
    end else begin
      w_sum = w_sum;
    end
    o_idx = w_sum[IW-1:0];
  end

endmodule

// File: rtl/lsu_arbiter.sv
// Round-robin arbiter sharing one memory channel among per-thread LSUs, one request at a time.
module lsu_arbiter
  import lsu_arbiter_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = LSU_COUNT,
  parameter int ADDR_BITS         = LSU_ADDR_BITS,
  parameter int DATA_BITS         = LSU_DATA_BITS
) (
  input logic          clk,
  input logic          reset,
  lsu_arbiter_if.slave bus
);

  localparam int N  = THREADS_PER_BLOCK;
  localparam int IW = idx_bits(N);

  arb_state_t                  r_state,  w_state;
  logic [IW-1:0]               r_idx,    w_idx;
  logic [IW-1:0]               r_rr_ptr, w_rr_ptr;
  logic                        r_is_write, w_is_write;
  logic [ADDR_BITS-1:0]        r_addr,   w_addr;
  logic [DATA_BITS-1:0]        r_wdata,  w_wdata;
  logic                        r_mem_rv, w_mem_rv;
  logic                        r_mem_wv, w_mem_wv;
  logic [N-1:0]                r_rd_ready, w_rd_ready;
  logic [N-1:0]                r_wr_ready, w_wr_ready;
  logic [N-1:0][DATA_BITS-1:0] r_rd_data,  w_rd_data;
  logic [N-1:0]                w_req;
  logic                        w_found;
  logic [IW-1:0]               w_pick;
  logic                        w_hold;

  assign w_req = bus.lsu_read_valid | bus.lsu_write_valid;

  rr_picker #(.N(N), .IW(IW)) u_picker (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_rr_ptr   <= '0;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mem_rv   <= MEM_REQ_OFF;
      r_mem_wv   <= MEM_REQ_OFF;
      r_rd_ready <= '0;
      r_wr_ready <= '0;
      r_rd_data  <= '0;
    end else begin
      r_state    <= w_state;
      r_idx      <= w_idx;
      r_rr_ptr   <= w_rr_ptr;
      r_is_write <= w_is_write;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_mem_rv   <= w_mem_rv;
      r_mem_wv   <= w_mem_wv;
      r_rd_ready <= w_rd_ready;
      r_wr_ready <= w_wr_ready;
      r_rd_data  <= w_rd_data;
    end
  end

  // Next state: grant, wait on memory, then hold ready until the LSU lets go of valid.
  always_comb begin
    w_state    = r_state;
    w_idx      = r_idx;
    w_rr_ptr   = r_rr_ptr;
    w_is_write = r_is_write;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_mem_rv   = r_mem_rv;
    w_mem_wv   = r_mem_wv;
    w_rd_ready = r_rd_ready;
    w_wr_ready = r_wr_ready;
    w_rd_data  = r_rd_data;
    w_hold     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_idx = w_pick;
          if (bus.lsu_read_valid[w_pick]) begin
            w_is_write = 1'b0;
            w_addr     = bus.lsu_read_address[w_pick];
            w_mem_rv   = MEM_REQ_ON;
            w_state    = ST_READ_WAIT;
          end else begin
            w_is_write = 1'b1;
            w_addr     = bus.lsu_write_address[w_pick];
            w_wdata    = bus.lsu_write_data[w_pick];
            w_mem_wv   = MEM_REQ_ON;
            w_state    = ST_WRITE_WAIT;
          end
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_READ_WAIT: begin
        if (bus.mem_read_ready) begin
          w_rd_data[r_idx]  = bus.mem_read_data;
          w_rd_ready[r_idx] = 1'b1;
          w_mem_rv          = MEM_REQ_OFF;
          w_state           = ST_RELAY;
        end else begin
          w_state = ST_READ_WAIT;
        end
      end
      ST_WRITE_WAIT: begin
        if (bus.mem_write_ready) begin
          w_wr_ready[r_idx] = 1'b1;
          w_mem_wv          = MEM_REQ_OFF;
          w_state           = ST_RELAY;
        end else begin
          w_state = ST_WRITE_WAIT;
        end
      end
      ST_RELAY: begin
        w_hold = r_is_write ? bus.lsu_write_valid[r_idx] : bus.lsu_read_valid[r_idx];
        if (!w_hold) begin
          w_rd_ready = '0;
          w_wr_ready = '0;
          w_rr_ptr   = IW'(wrap_inc(int'(r_idx), N));
          w_state    = ST_IDLE;
        end else begin
          w_state = ST_RELAY;
        end
      end
      default: begin
        w_mem_rv   = MEM_REQ_OFF;
        w_mem_wv   = MEM_REQ_OFF;
        w_rd_ready = '0;
        w_wr_ready = '0;
        w_state    = ST_IDLE;
      end
    endcase
  end

  assign bus.lsu_read_ready    = r_rd_ready;
  assign bus.lsu_read_data     = r_rd_data;
  assign bus.lsu_write_ready   = r_wr_ready;
  assign bus.mem_read_valid    = r_mem_rv;
  assign bus.mem_read_address  = r_addr;
  assign bus.mem_write_valid   = r_mem_wv;
  assign bus.mem_write_address = r_addr;
  assign bus.mem_write_data    = r_wdata;
  assign bus.busy              = (r_state != ST_IDLE);

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed scenarios followed by random traffic, checked against a queue-level round-robin model.
module tb_lsu_arbiter;
  import lsu_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lsu_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus ();

  lsu_arbiter #(.THREADS_PER_BLOCK(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [DW-1:0] ref_mem  [256];
  logic [DW-1:0] resp_mem [256];
  logic [DW-1:0] exp_rdata [N];
  bit            rd_pend [N];
  bit            wr_pend [N];
  logic [AW-1:0] rd_addr [N];
  logic [AW-1:0] wr_addr [N];
  logic [DW-1:0] wr_data [N];
  int            ref_ptr = 0;
  int            fixed_lat = -1;
  int            rd_cnt, wr_cnt, rd_lat, wr_lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Memory model with variable latency, plus per-cycle bus invariants.
  initial begin
    bus.mem_read_ready  = 1'b0;
    bus.mem_write_ready = 1'b0;
    bus.mem_read_data   = '0;
    rd_cnt = 0; wr_cnt = 0; rd_lat = 0; wr_lat = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        bus.mem_read_ready  = 1'b0;
        bus.mem_write_ready = 1'b0;
        rd_cnt = 0; wr_cnt = 0;
      end else begin
        check("one_mem_valid", 32'(bus.mem_read_valid & bus.mem_write_valid), 32'd0);
        check("ready_onehot", 32'($countones({bus.lsu_read_ready, bus.lsu_write_ready}) <= 1), 32'd1);
        if (bus.mem_read_ready) begin
          bus.mem_read_ready = 1'b0;
        end else if (bus.mem_read_valid) begin
          if (rd_cnt == 0) rd_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
          if (rd_cnt >= rd_lat) begin
            bus.mem_read_ready = 1'b1;
            bus.mem_read_data  = resp_mem[bus.mem_read_address];
            rd_cnt = 0;
          end else rd_cnt++;
        end else rd_cnt = 0;
        if (bus.mem_write_ready) begin
          bus.mem_write_ready = 1'b0;
        end else if (bus.mem_write_valid) begin
          if (wr_cnt == 0) wr_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
          if (wr_cnt >= wr_lat) begin
            bus.mem_write_ready = 1'b1;
            resp_mem[bus.mem_write_address] = bus.mem_write_data;
            wr_cnt = 0;
          end else wr_cnt++;
        end else wr_cnt = 0;
      end
    end
  end

  task automatic clear_lsus();
    bus.lsu_read_valid    = '0;
    bus.lsu_write_valid   = '0;
    bus.lsu_read_address  = '0;
    bus.lsu_write_address = '0;
    bus.lsu_write_data    = '0;
    for (int i = 0; i < N; i++) begin
      rd_pend[i] = 1'b0; wr_pend[i] = 1'b0; exp_rdata[i] = '0;
    end
    ref_ptr = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_lsus();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic post_read(input int i, input logic [AW-1:0] a);
    bus.lsu_read_valid[i] = 1'b1; bus.lsu_read_address[i] = a;
    rd_pend[i] = 1'b1; rd_addr[i] = a;
  endtask

  task automatic post_write(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.lsu_write_valid[i] = 1'b1; bus.lsu_write_address[i] = a; bus.lsu_write_data[i] = d;
    wr_pend[i] = 1'b1; wr_addr[i] = a; wr_data[i] = d;
  endtask

  // Predict the next grant from the pending set, wait for it, check it, then release it.
  task automatic expect_grant(input int max_hold);
    int  winner;
    bit  is_wr;
    int  c;
    int  hold;
    logic [N-1:0] onehot;
    winner = -1;
    for (int k = 0; k < N; k++) begin
      if (winner < 0 && (rd_pend[(ref_ptr + k) % N] || wr_pend[(ref_ptr + k) % N])) winner = (ref_ptr + k) % N;
    end
    if (winner < 0) return;
    is_wr  = !rd_pend[winner];
    onehot = N'(1) << winner;
    c = 0;
    @(negedge clk);
    while (bus.lsu_read_ready == '0 && bus.lsu_write_ready == '0 && c < 60) begin
      @(negedge clk);
      c++;
    end
    check("grant_timeout", 32'(c < 60), 32'd1);
    if (!is_wr) begin
      exp_rdata[winner] = ref_mem[rd_addr[winner]];
      check("read_ready", 32'(bus.lsu_read_ready), 32'(onehot));
      check("write_ready_quiet", 32'(bus.lsu_write_ready), 32'd0);
    end else begin
      ref_mem[wr_addr[winner]] = wr_data[winner];
      check("write_ready", 32'(bus.lsu_write_ready), 32'(onehot));
      check("read_ready_quiet", 32'(bus.lsu_read_ready), 32'd0);
      check("mem_write_data", 32'(resp_mem[wr_addr[winner]]), 32'(wr_data[winner]));
    end
    for (int i = 0; i < N; i++) check("read_data", 32'(bus.lsu_read_data[i]), 32'(exp_rdata[i]));
    hold = (max_hold > 0) ? int'($urandom_range(0, max_hold)) : 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("ready_held", 32'(is_wr ? bus.lsu_write_ready : bus.lsu_read_ready), 32'(onehot));
    end
    if (is_wr) begin
      bus.lsu_write_valid[winner] = 1'b0; wr_pend[winner] = 1'b0;
    end else begin
      bus.lsu_read_valid[winner] = 1'b0; rd_pend[winner] = 1'b0;
    end
    ref_ptr = (winner + 1) % N;
    @(negedge clk);
    check("ready_cleared", 32'({bus.lsu_read_ready, bus.lsu_write_ready}), 32'd0);
  endtask

  initial begin
    int c;
    for (int a = 0; a < 256; a++) begin
      ref_mem[a]  = 8'($urandom);
      resp_mem[a] = ref_mem[a];
    end
    do_reset();
    @(negedge clk);
    check("rst_mem_read_valid", 32'(bus.mem_read_valid), 32'd0);
    check("rst_mem_write_valid", 32'(bus.mem_write_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_readys", 32'({bus.lsu_read_ready, bus.lsu_write_ready}), 32'd0);
    check("rst_read_data", 32'(bus.lsu_read_data), 32'd0);

    // Single read from LSU2 with a slow memory.
    ref_mem[8'h10] = 8'h5A; resp_mem[8'h10] = 8'h5A;
    fixed_lat = 3;
    post_read(2, 8'h10);
    @(negedge clk);
    check("issue_valid", 32'(bus.mem_read_valid), 32'd1);
    check("issue_addr", 32'(bus.mem_read_address), 32'h10);
    check("issue_busy", 32'(bus.busy), 32'd1);
    expect_grant(0);
    check("single_data", 32'(bus.lsu_read_data[2]), 32'h5A);
    post_read(1, 8'h11); post_read(3, 8'h12);
    expect_grant(0);
    expect_grant(0);

    // All four read at once from pointer 0, then wrap back to LSU0.
    fixed_lat = 0;
    do_reset();
    for (int i = 0; i < N; i++) post_read(i, 8'(8'h40 + i));
    for (int i = 0; i < N; i++) expect_grant(1);
    post_read(0, 8'h50); post_read(3, 8'h51);
    expect_grant(0); expect_grant(0);

    // Pointer at 2: LSU3 ahead of LSU0.
    post_read(1, 8'h52);
    expect_grant(0);
    post_read(0, 8'h53); post_read(3, 8'h54);
    expect_grant(0); expect_grant(0);

    // Read and write from different LSUs contend.
    do_reset();
    post_read(0, 8'h21); post_write(1, 8'h20, 8'hC3);
    expect_grant(0);
    expect_grant(0);
    check("write_landed", 32'(resp_mem[8'h20]), 32'hC3);

    // Reset while waiting on memory.
    fixed_lat = 10;
    post_read(2, 8'h33);
    repeat (3) @(negedge clk);
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    clear_lsus();
    @(negedge clk);
    reset = 1'b0;
    check("abort_mem_valid", 32'(bus.mem_read_valid), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_readys", 32'({bus.lsu_read_ready, bus.lsu_write_ready}), 32'd0);
    check("abort_read_data", 32'(bus.lsu_read_data), 32'd0);
    fixed_lat = 1;
    post_read(3, 8'h34); post_read(0, 8'h35);
    expect_grant(0); expect_grant(0);

    // LSU1 withdraws its read while memory is still busy.
    fixed_lat = 4;
    post_read(1, 8'h36);
    repeat (2) @(negedge clk);
    bus.lsu_read_valid[1] = 1'b0; rd_pend[1] = 1'b0;
    c = 0;
    while (bus.lsu_read_ready == '0 && c < 40) begin
      @(negedge clk);
      c++;
    end
    exp_rdata[1] = ref_mem[8'h36];
    check("drop_timeout", 32'(c < 40), 32'd1);
    check("drop_ready", 32'(bus.lsu_read_ready), 32'b0010);
    check("drop_data", 32'(bus.lsu_read_data[1]), 32'(exp_rdata[1]));
    ref_ptr = 2;
    @(negedge clk);
    check("drop_pulse", 32'(bus.lsu_read_ready), 32'd0);
    check("drop_idle", 32'(bus.busy), 32'd0);

    // Random traffic over a small address window so reads see earlier writes.
    fixed_lat = -1;
    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!rd_pend[i] && $urandom_range(0, 2) == 0) post_read(i, 8'($urandom_range(0, 15)));
        if (!wr_pend[i] && $urandom_range(0, 3) == 0) post_write(i, 8'($urandom_range(0, 15)), 8'($urandom));
      end
      expect_grant(2);
    end
    for (int n = 0; n < 2 * N; n++) expect_grant(0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
